// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the flip-puzzle game controller and the display unit.
// Phase encoding and the 2-to-4 line decode used on the cell select bus.
package game_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SCRAMBLE = 3'd1,
      SETTLE   = 3'd2,
      PLAY     = 3'd3,
      WON      = 3'd4
   } state_t;

   localparam int SCR_CNT_W = 8;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      onehot4 = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/game_sequencer_rise_detect.sv
// Registered rising-edge detector with asynchronous active-low reset.
// The register holds "level was low last cycle", so a level already high at reset release is not an edge.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic was_low;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         was_low <= 1'b0;
      end else begin
         was_low <= ~level;
      end
   end

   assign rise = level & was_low;

endmodule

// File: rtl/game_sequencer.sv
// Game controller for the 4x4 flip-puzzle: timed random scramble, settle, user play, win hold.
// Drives the shared cell bus (row_column, x_nRow, fire); all outputs are registered.
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int SCRAMBLE_MOVES = 16,
   parameter int STEP_DIV       = 1000000,
   parameter int COUNT_W        = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [2:0]         rand_in,
   input  logic               user_fire,
   input  logic               user_nRow,
   input  logic [3:0]         user_row_column,
   input  logic               user_error,
   input  logic               win,
   output logic               fire,
   output logic               x_nRow,
   output logic [3:0]         row_column,
   output logic               scrambling,
   output logic               playing,
   output logic               won,
   output logic [COUNT_W-1:0] move_count,
   output logic [2:0]         state_dbg
);

   localparam int TIMER_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [TIMER_W-1:0]   TIMER_MAX = TIMER_W'(STEP_DIV - 1);
   localparam logic [SCR_CNT_W-1:0] SCR_LOAD  = SCR_CNT_W'(SCRAMBLE_MOVES);
   localparam logic [COUNT_W-1:0]   COUNT_MAX = '1;

   state_t               state, next_state;
   logic [TIMER_W-1:0]   timer, timer_d;
   logic [SCR_CNT_W-1:0] scr_cnt, scr_cnt_d;
   logic                 pend, pend_d;
   logic                 fire_d, x_nrow_d;
   logic [3:0]           row_column_d;
   logic [COUNT_W-1:0]   move_count_d;
   logic                 start_rise, fire_rise, user_ok, timer_done;

   rise_detect u_start_rise (
      .clk   (clk),
      .reset (reset),
      .level (start),
      .rise  (start_rise)
   );

   rise_detect u_fire_rise (
      .clk   (clk),
      .reset (reset),
      .level (user_fire),
      .rise  (fire_rise)
   );

   assign user_ok    = fire_rise & ~user_error & (|user_row_column);
   assign timer_done = (timer == TIMER_MAX);
   assign state_dbg  = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, WON: begin
            if (start_rise) next_state = SCRAMBLE;
         end
         SCRAMBLE: begin
            if (fire && (scr_cnt == SCR_CNT_W'(1))) next_state = SETTLE;
         end
         SETTLE: begin
            if (timer_done) next_state = win ? SCRAMBLE : PLAY;
         end
         PLAY: begin
            // start outranks both a fire rise and win; a flip in flight defers win by a cycle
            if (start_rise)           next_state = SCRAMBLE;
            else if (win && !user_ok) next_state = WON;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      timer_d      = timer;
      scr_cnt_d    = scr_cnt;
      pend_d       = 1'b0;
      fire_d       = 1'b0;
      x_nrow_d     = x_nRow;
      row_column_d = row_column;
      move_count_d = move_count;
      case (state)
         IDLE, WON: begin
            row_column_d = '0;
            if (start_rise) begin
               timer_d      = '0;
               scr_cnt_d    = SCR_LOAD;
               move_count_d = '0;
            end
         end
         SCRAMBLE: begin
            // step = STEP_DIV timer cycles, one select-settle cycle, then the strobe cycle
            if (fire) begin
               scr_cnt_d = scr_cnt - 1'b1;
               if (scr_cnt == SCR_CNT_W'(1)) begin
                  timer_d      = '0;
                  row_column_d = '0;
               end else begin
                  timer_d = timer + 1'b1;
               end
            end else if (pend) begin
               fire_d = 1'b1;
            end else if (timer_done) begin
               x_nrow_d     = rand_in[2];
               row_column_d = onehot4(rand_in[1:0]);
               timer_d      = '0;
               pend_d       = 1'b1;
            end else begin
               timer_d = timer + 1'b1;
            end
         end
         SETTLE: begin
            row_column_d = '0;
            if (timer_done) begin
               timer_d   = '0;
               scr_cnt_d = SCR_LOAD;
            end else begin
               timer_d = timer + 1'b1;
            end
         end
         PLAY: begin
            if (start_rise) begin
               row_column_d = '0;
               timer_d      = '0;
               scr_cnt_d    = SCR_LOAD;
               move_count_d = '0;
            end else begin
               x_nrow_d     = user_nRow;
               row_column_d = (user_error || (next_state == WON)) ? 4'b0000 : user_row_column;
               if (user_ok) begin
                  fire_d = 1'b1;
                  if (move_count != COUNT_MAX) move_count_d = move_count + 1'b1;
               end
            end
         end
         default: row_column_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer      <= '0;
         scr_cnt    <= '0;
         pend       <= 1'b0;
         fire       <= 1'b0;
         x_nRow     <= 1'b0;
         row_column <= 4'b0000;
         move_count <= '0;
         scrambling <= 1'b0;
         playing    <= 1'b0;
         won        <= 1'b0;
      end else begin
         timer      <= timer_d;
         scr_cnt    <= scr_cnt_d;
         pend       <= pend_d;
         fire       <= fire_d;
         x_nRow     <= x_nrow_d;
         row_column <= row_column_d;
         move_count <= move_count_d;
         scrambling <= (next_state == SCRAMBLE) || (next_state == SETTLE);
         playing    <= (next_state == PLAY);
         won        <= (next_state == WON);
      end
   end

endmodule
